// File: rtl/game_flow_controller_if.sv
// Control and status signals between the game flow controller and the rest of the game.
interface game_flow_controller_if;
  logic       start_btn;
  logic       frog_at_top;
  logic       frog_hit;
  logic [4:0] level;
  logic       reset_level;
  logic       level_up;
  logic       reset_frog;
  logic       move_enable;
  logic [2:0] lives;
  logic       game_over;
  logic       game_won;
  logic [2:0] state;

  modport master (
    input  start_btn, frog_at_top, frog_hit, level,
    output reset_level, level_up, reset_frog, move_enable, lives, game_over, game_won, state
  );

  modport slave (
    output start_btn, frog_at_top, frog_hit, level,
    input  reset_level, level_up, reset_frog, move_enable, lives, game_over, game_won, state
  );
endinterface

// File: rtl/game_flow_controller.sv
// Game flow FSM: idle, play, timed level/death pauses and game over, with lives tracking.
module game_flow_controller #(
  parameter int unsigned PAUSE_CYCLES = 25000000,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned MAX_LEVEL    = 31
) (
  input logic                     clk,
  input logic                     rst_n,
  game_flow_controller_if.master  bus
);

  localparam logic [24:0] PauseLast  = 25'(PAUSE_CYCLES - 1);
  localparam logic [2:0]  StartLives = 3'(START_LIVES);
  localparam logic [4:0]  MaxLevel   = 5'(MAX_LEVEL);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StPlay       = 3'd1,
    StLevelPause = 3'd2,
    StDeathPause = 3'd3,
    StGameOver   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [24:0] cnt_q, cnt_d;
  logic [2:0]  lives_q, lives_d;
  logic        start_q, top_q, hit_q, armed_q;
  logic        reset_level_q, reset_level_d;
  logic        level_up_q, level_up_d;
  logic        reset_frog_q, reset_frog_d;
  logic        game_won_q, game_won_d;
  logic        move_enable_q, game_over_q;
  logic        start_edge, top_edge, hit_edge;

  // armed_q blocks a button that was already held when reset was released.
  assign start_edge = bus.start_btn & ~start_q & armed_q;
  assign top_edge   = bus.frog_at_top & ~top_q;
  assign hit_edge   = bus.frog_hit & ~hit_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lives_d       = lives_q;
    game_won_d    = game_won_q;
    reset_level_d = 1'b0;
    level_up_d    = 1'b0;
    reset_frog_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d       = StPlay;
          reset_level_d = 1'b1;
          reset_frog_d  = 1'b1;
          lives_d       = StartLives;
          game_won_d    = 1'b0;
        end
      end
      StPlay: begin
        // A hit takes priority over a simultaneous top crossing.
        if (hit_edge) begin
          if (lives_q > 3'd1) begin
            state_d      = StDeathPause;
            lives_d      = lives_q - 3'd1;
            reset_frog_d = 1'b1;
            cnt_d        = '0;
          end else begin
            state_d    = StGameOver;
            lives_d    = 3'd0;
            game_won_d = 1'b0;
          end
        end else if (top_edge) begin
          if (bus.level < MaxLevel) begin
            state_d      = StLevelPause;
            level_up_d   = 1'b1;
            reset_frog_d = 1'b1;
            cnt_d        = '0;
          end else begin
            state_d    = StGameOver;
            game_won_d = 1'b1;
          end
        end
      end
      StLevelPause, StDeathPause: begin
        if (cnt_q == PauseLast) begin
          state_d = StPlay;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end
      StGameOver: begin
        if (start_edge) begin
          state_d    = StIdle;
          game_won_d = 1'b0;
          lives_d    = 3'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      lives_q       <= '0;
      start_q       <= 1'b0;
      top_q         <= 1'b0;
      hit_q         <= 1'b0;
      armed_q       <= 1'b0;
      reset_level_q <= 1'b0;
      level_up_q    <= 1'b0;
      reset_frog_q  <= 1'b0;
      game_won_q    <= 1'b0;
      move_enable_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lives_q       <= lives_d;
      start_q       <= bus.start_btn;
      top_q         <= bus.frog_at_top;
      hit_q         <= bus.frog_hit;
      armed_q       <= armed_q | ~bus.start_btn;
      reset_level_q <= reset_level_d;
      level_up_q    <= level_up_d;
      reset_frog_q  <= reset_frog_d;
      game_won_q    <= game_won_d;
      move_enable_q <= (state_d == StPlay);
      game_over_q   <= (state_d == StGameOver);
    end
  end

  assign bus.state       = state_q;
  assign bus.lives       = lives_q;
  assign bus.reset_level = reset_level_q;
  assign bus.level_up    = level_up_q;
  assign bus.reset_frog  = reset_frog_q;
  assign bus.move_enable = move_enable_q;
  assign bus.game_over   = game_over_q;
  assign bus.game_won    = game_won_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios plus random play against a game-rule model.
module tb_game_flow_controller;

  localparam int P      = 16;
  localparam int StartL = 3;
  localparam int MaxL   = 31;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_flow_controller_if bus();

  game_flow_controller #(
    .PAUSE_CYCLES(P)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int lu_cnt = 0;
  int rf_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game rules: mode numbers are the debug codes; a pause is a countdown of remaining cycles.
  typedef struct {
    int mode;
    int lives;
    int pause_left;
    bit sp, tp, hp;
    bit rl, lu, rf, won;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = 0; r.lives = 0; r.pause_left = 0;
    r.sp = 1'b1;  // a button held through reset counts as already pressed
    r.tp = 1'b0; r.hp = 1'b0;
    r.rl = 1'b0; r.lu = 1'b0; r.rf = 1'b0; r.won = 1'b0;
    return r;
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input bit sb, input bit ft, input bit fh,
                                      input int lvl);
    mdl_t n = m;
    bit se = sb && !m.sp;
    bit te = ft && !m.tp;
    bit he = fh && !m.hp;
    n.sp = sb; n.tp = ft; n.hp = fh;
    n.rl = 1'b0; n.lu = 1'b0; n.rf = 1'b0;
    if (m.mode == 0) begin
      if (se) begin
        n.mode = 1; n.rl = 1'b1; n.rf = 1'b1; n.lives = StartL; n.won = 1'b0;
      end
    end else if (m.mode == 1) begin
      if (he) begin
        if (m.lives > 1) begin
          n.lives = m.lives - 1; n.rf = 1'b1; n.mode = 3; n.pause_left = P;
        end else begin
          n.lives = 0; n.mode = 4; n.won = 1'b0;
        end
      end else if (te) begin
        if (lvl < MaxL) begin
          n.lu = 1'b1; n.rf = 1'b1; n.mode = 2; n.pause_left = P;
        end else begin
          n.mode = 4; n.won = 1'b1;
        end
      end
    end else if (m.mode == 2 || m.mode == 3) begin
      n.pause_left = m.pause_left - 1;
      if (n.pause_left == 0) n.mode = 1;
    end else if (m.mode == 4) begin
      if (se) begin
        n.mode = 0; n.won = 1'b0; n.lives = 0;
      end
    end
    return n;
  endfunction

  mdl_t m;

  initial begin
    m = mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m = mdl_reset();
      else m = model_next(m, bus.start_btn, bus.frog_at_top, bus.frog_hit, int'(bus.level));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.level_up === 1'b1) lu_cnt++;
      if (bus.reset_frog === 1'b1) rf_cnt++;
      if (chk_en) begin
        check("state", int'(bus.state), m.mode);
        check("lives", int'(bus.lives), m.lives);
        check("move_enable", int'(bus.move_enable), int'(m.mode == 1));
        check("game_over", int'(bus.game_over), int'(m.mode == 4));
        check("game_won", int'(bus.game_won), int'(m.won));
        check("reset_level", int'(bus.reset_level), int'(m.rl));
        check("level_up", int'(bus.level_up), int'(m.lu));
        check("reset_frog", int'(bus.reset_frog), int'(m.rf));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1;
    cyc(1);
    bus.start_btn = 1'b0;
  endtask

  int n;
  int base_lu;
  int base_rf;

  initial begin
    bus.start_btn   = 1'b1;
    bus.frog_at_top = 1'b0;
    bus.frog_hit    = 1'b0;
    bus.level       = 5'd1;
    cyc(2);
    chk_en = 1'b1;
    check("rst_state", int'(bus.state), 0);
    check("rst_lives", int'(bus.lives), 0);
    check("rst_move", int'(bus.move_enable), 0);

    // Button held across reset release must not start the game.
    rst_n = 1'b1;
    cyc(3);
    check("held_start_ignored", int'(bus.state), 0);
    bus.start_btn = 1'b0;
    cyc(1);
    bus.start_btn = 1'b1;
    cyc(1);
    check("start_reset_level", int'(bus.reset_level), 1);
    check("start_reset_frog", int'(bus.reset_frog), 1);
    check("start_lives", int'(bus.lives), 3);
    check("start_state", int'(bus.state), 1);
    check("start_move", int'(bus.move_enable), 1);
    cyc(1);
    check("start_pulse_end", int'(bus.reset_level), 0);
    bus.start_btn = 1'b0;

    // Top row held for 10 cycles at level 4.
    bus.level = 5'd4;
    base_lu = lu_cnt;
    base_rf = rf_cnt;
    bus.frog_at_top = 1'b1;
    cyc(1);
    check("lvl_pause_state", int'(bus.state), 2);
    n = 0;
    while (bus.state == 3'd2 && n < 40) begin
      n++;
      if (n == 10) bus.frog_at_top = 1'b0;
      cyc(1);
    end
    bus.frog_at_top = 1'b0;
    check("lvl_pause_len", n, 16);
    check("lvl_pause_back", int'(bus.state), 1);
    check("lvl_up_count", lu_cnt - base_lu, 1);
    check("lvl_rf_count", rf_cnt - base_rf, 1);

    // First hit: 3 -> 2.
    bus.frog_hit = 1'b1;
    cyc(1);
    bus.frog_hit = 1'b0;
    check("hit1_lives", int'(bus.lives), 2);
    check("hit1_state", int'(bus.state), 3);
    cyc(P);
    check("hit1_back", int'(bus.state), 1);

    // Simultaneous top and hit at 2 lives: hit wins.
    base_lu = lu_cnt;
    bus.frog_at_top = 1'b1;
    bus.frog_hit    = 1'b1;
    cyc(1);
    check("both_lives", int'(bus.lives), 1);
    check("both_state", int'(bus.state), 3);
    cyc(1);
    check("both_no_lvlup", lu_cnt - base_lu, 0);
    bus.frog_at_top = 1'b0;
    bus.frog_hit    = 1'b0;
    cyc(P);
    check("both_back", int'(bus.state), 1);

    // Last life.
    bus.frog_hit = 1'b1;
    cyc(1);
    bus.frog_hit = 1'b0;
    check("dead_lives", int'(bus.lives), 0);
    check("dead_state", int'(bus.state), 4);
    check("dead_over", int'(bus.game_over), 1);
    check("dead_won", int'(bus.game_won), 0);
    cyc(3);
    check("dead_held", int'(bus.game_over), 1);
    press_start();
    check("dead_to_idle", int'(bus.state), 0);
    cyc(1);

    // Win at max level.
    press_start();
    check("win_play", int'(bus.state), 1);
    bus.level = 5'd31;
    base_lu = lu_cnt;
    bus.frog_at_top = 1'b1;
    cyc(1);
    check("win_state", int'(bus.state), 4);
    check("win_flag", int'(bus.game_won), 1);
    cyc(1);
    check("win_no_lvlup", lu_cnt - base_lu, 0);
    bus.frog_at_top = 1'b0;
    press_start();
    check("win_to_idle", int'(bus.state), 0);
    cyc(1);

    // Asynchronous reset in the middle of a death pause.
    bus.level = 5'd4;
    press_start();
    bus.frog_hit = 1'b1;
    cyc(1);
    bus.frog_hit = 1'b0;
    check("mid_pause_state", int'(bus.state), 3);
    cyc(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(bus.state), 0);
    check("async_rst_lives", int'(bus.lives), 0);
    cyc(1);
    rst_n = 1'b1;

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.start_btn = ~bus.start_btn;
      if ($urandom_range(0, 5) == 0) bus.frog_at_top = ~bus.frog_at_top;
      if ($urandom_range(0, 7) == 0) bus.frog_hit = ~bus.frog_hit;
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 3) == 0) bus.level = 5'd31;
        else bus.level = 5'($urandom_range(1, 30));
      end
      if ($urandom_range(0, 699) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
